mem_server: RTL and testbench

MEM_SERVER -- requirements
Module: mem_server

---
 rtl/mem_server_pkg.sv | 20 ++
 rtl/mem_server_ram.sv | 25 ++
 rtl/mem_server.sv | 187 ++++++++++++++++++
 tb/tb_mem_server.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_server_pkg.sv
// Shared protocol constants and state encoding for the UART memory responder.
package mem_server_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] RSP_ACK  = 8'hAA;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        MASK  = 3'd3,
        EXEC  = 3'd4,
        SEND  = 3'd5,
        ACK   = 3'd6,
        ERR   = 3'd7
    } state_t;

endpackage

// File: rtl/mem_server_ram.sv
// Single-port synchronous RAM: 32-bit words, per-byte write enables, registered read data.
module mem_server_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 re_i,
    input  logic [3:0]           we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [2**ADDR_BITS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_server.sv
// UART memory-protocol responder: parses read/write frames, accesses local RAM, returns responses.
// Optional inter-byte timeout enabled by defining MEM_SERVER_TIMEOUT_EN.
module mem_server
    import mem_server_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int TIMEOUT   = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       recv_flag,
    input  logic [7:0] recv_data,
    input  logic       receivable,
    output logic       send_flag,
    output logic [7:0] send_data,
    input  logic       sendable,
    output logic       busy
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;

    logic        consume;
    logic        in_rx_frame;
    logic        tmo_hit;
    logic        ram_re;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;

    assign in_rx_frame = (state_q == ADDR) || (state_q == WDATA) || (state_q == MASK);
    assign consume     = !RST && receivable &&
                         ((state_q == IDLE) || in_rx_frame);

`ifdef MEM_SERVER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (in_rx_frame && !consume) begin
            tmo_d   = tmo_q + TW'(1);
            tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT > 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        recv_flag = consume;
        send_flag = 1'b0;
        send_data = 8'h00;
        ram_re    = 1'b0;
        ram_we    = 4'b0000;

        case (state_q)
            IDLE: begin
                if (consume) begin
                    is_wr_d = (recv_data == OP_WRITE);
                    state_d = (recv_data == OP_READ || recv_data == OP_WRITE) ? ADDR : ERR;
                end
            end
            ADDR: begin
                if (consume) begin
                    addr_d = {recv_data, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = is_wr_q ? WDATA : EXEC;
                end
            end
            WDATA: begin
                if (consume) begin
                    wdata_d = {recv_data, wdata_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = MASK;
                end
            end
            MASK: begin
                if (consume) begin
                    mask_d  = recv_data[3:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_wr_q) begin
                    ram_we  = mask_q;
                    state_d = ACK;
                end else begin
                    ram_re  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                case (cnt_q)
                    2'd0:    send_data = ram_rdata[7:0];
                    2'd1:    send_data = ram_rdata[15:8];
                    2'd2:    send_data = ram_rdata[23:16];
                    default: send_data = ram_rdata[31:24];
                endcase
                if (sendable) begin
                    send_flag = 1'b1;
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = IDLE;
                end
            end
            ACK: begin
                send_data = RSP_ACK;
                if (sendable) begin
                    send_flag = 1'b1;
                    state_d   = IDLE;
                end
            end
            ERR: begin
                send_data = RSP_ERR;
                if (sendable) begin
                    send_flag = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An abandoned partial frame leaves silently with counters rewound.
        if (tmo_hit) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end

        if (RST) begin
            send_flag = 1'b0;
            send_data = 8'h00;
            ram_re    = 1'b0;
            ram_we    = 4'b0000;
        end
    end

    assign busy = !RST && (state_q != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        is_wr_q <= is_wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        mask_q  <= mask_d;
    end

    logic unused_addr;
    assign unused_addr = ^{addr_q[31:ADDR_BITS+2], addr_q[1:0]};

    mem_server_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk_i   (CLK),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .addr_i  (addr_q[ADDR_BITS+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_mem_server.sv
// Bench for mem_server: UART queue model, reference memory model and per-cycle response checking.
module tb_mem_server;

    localparam int AB = 10;
`ifdef MEM_SERVER_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       recv_flag;
    logic [7:0] recv_data = 8'h00;
    logic       receivable = 1'b0;
    logic       send_flag;
    logic [7:0] send_data;
    logic       sendable = 1'b1;
    logic       busy;

    always #5 clk = ~clk;

    mem_server #(.ADDR_BITS(AB), .TIMEOUT(TMO)) dut (
        .CLK        (clk),
        .RST        (rst),
        .recv_flag  (recv_flag),
        .recv_data  (recv_data),
        .receivable (receivable),
        .send_flag  (send_flag),
        .send_data  (send_data),
        .sendable   (sendable),
        .busy       (busy)
    );

    typedef logic [7:0] byte_q_t[$];

    byte_q_t     rxq;
    byte_q_t     expq;
    byte_q_t     gotq;
    logic [31:0] mm [2**AB];
    int          ntot = 0;
    int          nbad = 0;
    logic        hold_send = 1'b0;
    logic        hold_ref_v = 1'b0;
    logic [7:0]  hold_ref = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        receivable = (rxq.size() != 0);
        recv_data  = receivable ? rxq[0] : 8'h00;
        sendable   = !hold_send;
    endtask

    // One clock cycle: check outputs mid-cycle, then apply UART pops and new inputs.
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = recv_flag;
        if (recv_flag) chk("recv_when_receivable", 32'(receivable), 32'd1);
        if (!sendable) begin
            chk("hold_no_send", 32'(send_flag), 32'd0);
            if (hold_ref_v) chk("hold_data_stable", 32'(send_data), 32'(hold_ref));
            else begin
                hold_ref   = send_data;
                hold_ref_v = 1'b1;
            end
        end else begin
            hold_ref_v = 1'b0;
        end
        if (send_flag) begin
            gotq.push_back(send_data);
            if (expq.size() == 0) begin
                ntot++;
                nbad++;
                $display("FAIL unexpected_tx: got %0h expected no byte at %0t", send_data, $time);
            end else begin
                chk("tx_byte", 32'(send_data), 32'(expq.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        if (pop && rxq.size() != 0) void'(rxq.pop_front());
        drive_inputs();
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((rxq.size() != 0 || expq.size() != 0 || busy) && n < 2000);
        if (n >= 2000) begin
            ntot++;
            nbad++;
            $display("FAIL %s_timeout: rx=%0d exp=%0d left, required 0", nm, rxq.size(), expq.size());
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (2**AB));
    endfunction

    task automatic push32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) rxq.push_back(v[8*i +: 8]);
    endtask

    task automatic frame_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
        rxq.push_back(8'h02);
        push32(a);
        push32(d);
        rxq.push_back(m);
        for (int i = 0; i < 4; i++) if (m[i]) mm[widx(a)][8*i +: 8] = d[8*i +: 8];
        expq.push_back(8'hAA);
    endtask

    task automatic frame_read(input logic [31:0] a);
        logic [31:0] w;
        rxq.push_back(8'h01);
        push32(a);
        w = mm[widx(a)];
        for (int i = 0; i < 4; i++) expq.push_back(w[8*i +: 8]);
    endtask

    task automatic frame_bad(input logic [7:0] op);
        rxq.push_back(op);
        expq.push_back(8'hEE);
    endtask

    task automatic check_got(input string nm, input byte_q_t exp);
        chk({nm, "_count"}, 32'(gotq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < gotq.size(); i++)
            chk(nm, 32'(gotq[i]), 32'(exp[i]));
        gotq.delete();
    endtask

    initial begin
        byte_q_t lit;
        int      n;

        for (int i = 0; i < 2**AB; i++) mm[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_send_flag", 32'(send_flag), 32'd0);
        chk("rst_recv_flag", 32'(recv_flag), 32'd0);
        chk("rst_send_data", 32'(send_data), 32'd0);
        @(posedge clk);
        #1;

        // Zero the words that are read back so model and RAM agree from the start.
        frame_write(32'h10, 32'h0, 8'h0F);
        frame_write(32'h20, 32'h0, 8'h0F);
        frame_write(32'h0, 32'h0, 8'h0F);
        drain("init");
        gotq.delete();

        frame_write(32'h10, 32'h12345678, 8'h0F);
        frame_read(32'h10);
        drain("wr_rd");
        lit = '{8'hAA, 8'h78, 8'h56, 8'h34, 8'h12};
        check_got("wr_rd_bytes", lit);

        frame_write(32'h20, 32'h12345678, 8'h0F);
        frame_write(32'h20, 32'hDEADBEEF, 8'h05);
        frame_read(32'h20);
        drain("mask");
        lit = '{8'hAA, 8'hAA, 8'hEF, 8'h56, 8'hAD, 8'h12};
        check_got("mask_bytes", lit);

        frame_bad(8'h7F);
        frame_read(32'h10);
        drain("bad_op");
        lit = '{8'hEE, 8'h78, 8'h56, 8'h34, 8'h12};
        check_got("bad_op_bytes", lit);

        frame_write(32'h1000, 32'hCAFEBABE, 8'h0F);
        frame_read(32'h0);
        drain("wrap");
        lit = '{8'hAA, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
        check_got("wrap_bytes", lit);

        frame_write(32'h10, 32'h0, 8'h00);
        frame_write(32'h10, 32'hFFFFFFFF, 8'hF0);
        frame_read(32'h13);
        drain("nomask");
        lit = '{8'hAA, 8'hAA, 8'h78, 8'h56, 8'h34, 8'h12};
        check_got("nomask_bytes", lit);

        frame_read(32'h20);
        n = 0;
        while (gotq.size() < 1 && n < 200) begin
            tick();
            n++;
        end
        chk("hold_first_byte_seen", 32'(gotq.size()), 32'd1);
        hold_send = 1'b1;
        drive_inputs();
        repeat (50) tick();
        chk("hold_data_value", 32'(hold_ref), 32'h56);
        hold_send = 1'b0;
        drive_inputs();
        drain("hold");
        lit = '{8'hEF, 8'h56, 8'hAD, 8'h12};
        check_got("hold_bytes", lit);

        frame_read(32'h10);
        n = 0;
        while (gotq.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        rst = 1'b1;
        expq.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        lit = '{8'h78, 8'h56};
        check_got("midrst_bytes", lit);
        frame_read(32'h10);
        drain("after_rst");
        lit = '{8'h78, 8'h56, 8'h34, 8'h12};
        check_got("after_rst_bytes", lit);

`ifdef MEM_SERVER_TIMEOUT_EN
        rxq.push_back(8'h01);
        rxq.push_back(8'h10);
        drive_inputs();
        repeat (2 + TMO) tick();
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_no_tx", 32'(gotq.size()), 32'd0);
        frame_read(32'h10);
        drain("tmo_read");
        lit = '{8'h78, 8'h56, 8'h34, 8'h12};
        check_got("tmo_read_bytes", lit);
`endif

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
